// File: rtl/usb_attach_pkg.sv
// Shared types and 48 MHz timing defaults for the USB attach sequencer.
package usb_attach_pkg;

  typedef enum logic [1:0] {
    WAIT_CONNECT = 2'd0,
    ATTACHED     = 2'd1,
    BUS_RESET    = 2'd2,
    DETACH       = 2'd3
  } attach_state_e;

  // Line states encoded as {dp, dn}
  localparam logic [1:0] LINE_SE0 = 2'b00;
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;

  localparam int unsigned DEF_CONNECT_DELAY    = 48000;
  localparam int unsigned DEF_SE0_RESET_CYCLES = 120;
  localparam int unsigned DEF_DETACH_CYCLES    = 480000;
  localparam int unsigned DEF_SUSPEND_CYCLES   = 144000;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/usb_attach_seq_sync2.sv
// Two-flop synchronizer with a selectable reset level for one asynchronous line.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic clk_reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_in or negedge clk_reset_n) begin
    if (!clk_reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/usb_attach_seq.sv
// USB attach sequencer: delayed D+ pull-up, SE0 bus-reset qualification, soft detach.
// Optional suspend detection is built when USB_SUSPEND_DETECT_EN is defined.
module usb_attach_seq
  import usb_attach_pkg::*;
#(
  parameter int unsigned CONNECT_DELAY    = DEF_CONNECT_DELAY,
  parameter int unsigned SE0_RESET_CYCLES = DEF_SE0_RESET_CYCLES,
  parameter int unsigned DETACH_CYCLES    = DEF_DETACH_CYCLES,
  parameter int unsigned SUSPEND_CYCLES   = DEF_SUSPEND_CYCLES
) (
  input  logic clk_in,
  input  logic clk_reset_n,
  input  logic usb_dp_in,
  input  logic usb_dn_in,
  input  logic detach_req,
  output logic usb_pu,
  output logic usb_bus_reset,
  output logic attached,
  output logic usb_suspend
);

  localparam int unsigned CNT_W =
    $clog2(max4(CONNECT_DELAY, SE0_RESET_CYCLES, DETACH_CYCLES, SUSPEND_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] CONNECT_LAST = CNT_W'(CONNECT_DELAY - 1);
  localparam logic [CNT_W-1:0] SE0_LAST     = CNT_W'(SE0_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] DETACH_LAST  = CNT_W'(DETACH_CYCLES - 1);

  attach_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pu_q, pu_d;
  logic             bus_reset_q, bus_reset_d;
  logic             attached_q, attached_d;
  logic             dp_s, dn_s;
  logic             line_se0;

  // Idle bus is J, so the synchronizers come out of reset as dp=1, dn=0
  sync2 #(.RST_VAL(1'b1)) u_sync_dp (
    .clk_in      (clk_in),
    .clk_reset_n (clk_reset_n),
    .d_i         (usb_dp_in),
    .q_o         (dp_s)
  );

  sync2 #(.RST_VAL(1'b0)) u_sync_dn (
    .clk_in      (clk_in),
    .clk_reset_n (clk_reset_n),
    .d_i         (usb_dn_in),
    .q_o         (dn_s)
  );

  assign line_se0 = ({dp_s, dn_s} == LINE_SE0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_CONNECT: if (cnt_q == CONNECT_LAST)         state_d = ATTACHED;
      ATTACHED:     if (line_se0 && cnt_q == SE0_LAST) state_d = BUS_RESET;
      BUS_RESET:    if (!line_se0)                     state_d = ATTACHED;
      DETACH:       if (cnt_q == DETACH_LAST)          state_d = WAIT_CONNECT;
      default:                                         state_d = WAIT_CONNECT;
    endcase
    // Soft detach wins over everything, including a same-cycle SE0 qualification
    if (detach_req) state_d = DETACH;
  end

  // One shared counter: phase timer in WAIT_CONNECT/DETACH, SE0 run length in ATTACHED
  always_comb begin
    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    if (state_d != state_q || detach_req) begin
      cnt_d = '0;
    end else if (state_q == ATTACHED && !line_se0) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    pu_d        = (state_q == ATTACHED) || (state_q == BUS_RESET);
    bus_reset_d = (state_q == BUS_RESET);
    attached_d  = (state_q == ATTACHED);
  end

  always_ff @(posedge clk_in or negedge clk_reset_n) begin
    if (!clk_reset_n) begin
      state_q     <= WAIT_CONNECT;
      cnt_q       <= '0;
      pu_q        <= 1'b0;
      bus_reset_q <= 1'b0;
      attached_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pu_q        <= pu_d;
      bus_reset_q <= bus_reset_d;
      attached_q  <= attached_d;
    end
  end

  assign usb_pu        = pu_q;
  assign usb_bus_reset = bus_reset_q;
  assign attached      = attached_q;

`ifdef USB_SUSPEND_DETECT_EN
  localparam int unsigned      SUS_W    = $clog2(SUSPEND_CYCLES) + 1;
  localparam logic [SUS_W-1:0] SUS_LAST = SUS_W'(SUSPEND_CYCLES - 1);

  logic             line_j;
  logic [SUS_W-1:0] sus_cnt_q, sus_cnt_d;
  logic             suspend_q, suspend_d;

  assign line_j = ({dp_s, dn_s} == LINE_J);

  // Suspend holds only while J persists in ATTACHED; any other cycle drops it
  always_comb begin
    sus_cnt_d = '0;
    suspend_d = 1'b0;
    if (state_q == ATTACHED && line_j) begin
      sus_cnt_d = (sus_cnt_q == '1) ? sus_cnt_q : sus_cnt_q + SUS_W'(1);
      suspend_d = (sus_cnt_q >= SUS_LAST);
    end
  end

  always_ff @(posedge clk_in or negedge clk_reset_n) begin
    if (!clk_reset_n) begin
      sus_cnt_q <= '0;
      suspend_q <= 1'b0;
    end else begin
      sus_cnt_q <= sus_cnt_d;
      suspend_q <= suspend_d;
    end
  end

  assign usb_suspend = suspend_q;
`else
  assign usb_suspend = 1'b0;
`endif

endmodule
